// File: rtl/cpu_ifetch_pkg.sv
// Shared types and helpers for the Wishbone instruction-fetch master and its prefetch FIFO.
package cpu_ifetch_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StReq   = 2'd1,
    StDrain = 2'd2
  } ifetch_state_e;

  function automatic int unsigned bytes_per_word(int unsigned data_width);
    return data_width / 8;
  endfunction

  function automatic int unsigned ptr_width(int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/cpu_ifetch_fifo.sv
// Synchronous prefetch FIFO; power-of-two depth so pointers wrap naturally.
module cpu_ifetch_fifo
  import cpu_ifetch_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = ptr_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [PtrW:0]    count_o
);

  localparam logic [PtrW:0] DepthC = (PtrW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DepthC);
  assign do_pop  = pop_i & ~empty_o;
  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | do_pop);
  assign count_o = count_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i && !rst_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push != do_pop) count_q <= do_push ? count_q + 1'b1 : count_q - 1'b1;
    end
  end

endmodule

// File: rtl/cpu_ifetch_wb.sv
// Wishbone classic instruction-fetch master with prefetch queue and branch flush.
// Optional bus-error support is enabled by defining CPU_IFETCH_ERR_EN.
module cpu_ifetch_wb
  import cpu_ifetch_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h00001000
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  output logic [ADDR_WIDTH-1:0]     wb_adr_o,
  input  logic [DATA_WIDTH-1:0]     wb_dat_i,
  output logic [DATA_WIDTH/8-1:0]   wb_sel_o,
  output logic                      wb_we_o,
  output logic                      wb_cyc_o,
  output logic                      wb_stb_o,
  input  logic                      wb_ack_i,
  input  logic                      branch_flag_i,
  input  logic [ADDR_WIDTH-1:0]     branch_target_i,
  output logic [DATA_WIDTH-1:0]     data_o,
  output logic [ADDR_WIDTH-1:0]     pc_o,
  output logic                      valid_o,
  input  logic                      ready_i
`ifdef CPU_IFETCH_ERR_EN
  ,
  input  logic                      wb_err_i,
  output logic                      fetch_err_o
`endif
);

  localparam int unsigned Bpw  = bytes_per_word(DATA_WIDTH);
  localparam int unsigned PtrW = ptr_width(DEPTH);
  localparam int unsigned EntW = ADDR_WIDTH + DATA_WIDTH;
  localparam logic [PtrW:0]           DepthC    = (PtrW + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0]   Step      = ADDR_WIDTH'(Bpw);
  localparam logic [ADDR_WIDTH-1:0]   AlignMask = ~(ADDR_WIDTH'(Bpw - 1));

  ifetch_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0]   fetch_addr_q, fetch_addr_d;
  logic [PtrW:0]           count, count_after;
  logic                    full, empty, push, pop, bus_err, err_block;
  logic [EntW-1:0]         head;

  assign pop         = valid_o & ready_i & ~branch_flag_i;
  assign count_after = count + (PtrW + 1)'(1) - (PtrW + 1)'(pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      fetch_addr_q <= RESET_PC;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    push         = 1'b0;
    unique case (state_q)
      StIdle: if (!branch_flag_i && !full && !err_block) state_d = StReq;
      StReq: begin
        if (branch_flag_i) begin
          // A cycle still waiting for its ack must be closed out before refetching.
          state_d = (wb_ack_i || bus_err) ? StIdle : StDrain;
        end else if (wb_ack_i) begin
          push         = 1'b1;
          fetch_addr_d = fetch_addr_q + Step;
          state_d      = (count_after < DepthC) ? StReq : StIdle;
        end else if (bus_err) begin
          state_d = StIdle;
        end
      end
      StDrain: if (wb_ack_i || bus_err) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (branch_flag_i) fetch_addr_d = branch_target_i & AlignMask;
  end

  always_comb begin
    wb_cyc_o = (state_q != StIdle);
    wb_stb_o = (state_q != StIdle);
    wb_adr_o = fetch_addr_q;
  end

  assign wb_sel_o = '1;
  assign wb_we_o  = 1'b0;

`ifdef CPU_IFETCH_ERR_EN
  logic fetch_err_q, err_set;
  assign err_set = (state_q == StReq) & wb_err_i & ~wb_ack_i & ~branch_flag_i;

  always_ff @(posedge clk_i) begin
    if (rst_i || branch_flag_i) fetch_err_q <= 1'b0;
    else if (err_set)           fetch_err_q <= 1'b1;
  end

  assign bus_err     = wb_err_i;
  assign err_block   = fetch_err_q;
  assign fetch_err_o = fetch_err_q;
`else
  assign bus_err   = 1'b0;
  assign err_block = 1'b0;
`endif

  cpu_ifetch_fifo #(
    .WIDTH (EntW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (branch_flag_i),
    .push_i  (push & ~branch_flag_i),
    .pop_i   (pop),
    .wdata_i ({fetch_addr_q, wb_dat_i}),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign valid_o = ~empty;
  assign pc_o    = head[EntW-1:DATA_WIDTH];
  assign data_o  = head[DATA_WIDTH-1:0];

endmodule
